// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  // Next-PC source select; codes 6 and 7 are reserved and fall back to pc+4.
  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Only computed control-flow targets are alignment-checked; CSR values and pc+4 are trusted.
  function automatic logic src_is_checked(input logic [2:0] sel);
    return (sel == PC_JALR) || (sel == PC_BRANCH) || (sel == PC_JAL);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/ready fetch channel.
interface pc_fetch_ctrl_if #(
  parameter int unsigned n = 32
);

  logic         imem_req;
  logic [n-1:0] imem_addr;
  logic         imem_ready;
  logic [n-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_ctrl_pc_next_mux.sv
// Combinational next-PC source select with target-misalignment flag.
module pc_next_mux
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [2:0]   pc_source,
  input  logic [n-1:0] pc_plus4,
  input  logic [n-1:0] jal,
  input  logic [n-1:0] branch,
  input  logic [n-1:0] jalr,
  input  logic [n-1:0] mtvec,
  input  logic [n-1:0] mepc,
  output logic [n-1:0] target_c,
  output logic         misaligned_c
);

  // Source select; reserved codes behave as sequential fetch.
  always_comb begin
    target_c = pc_plus4;
    case (pc_source)
      PC_JALR:   target_c = jalr;
      PC_BRANCH: target_c = branch;
      PC_JAL:    target_c = jal;
      PC_MTVEC:  target_c = mtvec;
      PC_MEPC:   target_c = mepc;
      default:   target_c = pc_plus4;
    endcase
  end

  // Word alignment check on computed jump/branch targets only.
  always_comb begin
    misaligned_c = src_is_checked(pc_source) && (target_c[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC register, next-PC commit and instruction fetch handshake.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned n         = 32,
  parameter logic [n-1:0] RESET_VEC = n'(RESET_VEC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic                   pc_write,
  input  logic [2:0]             pc_source,
  input  logic [n-1:0]           jal,
  input  logic [n-1:0]           branch,
  input  logic [n-1:0]           jalr,
  input  logic [n-1:0]           mtvec,
  input  logic [n-1:0]           mepc,
  pc_fetch_ctrl_if.master        imem,
  output logic [n-1:0]           pc,
  output logic [n-1:0]           pc_plus4,
  output logic [n-1:0]           ir,
  output logic                   ir_valid,
  output logic                   busy,
  output logic                   misalign_trap
);

  fetch_state_t state_q, state_d;

  logic [n-1:0] target_c;
  logic         misaligned_c;
  logic         write_ok_c;

  logic [n-1:0] pend_q;
  logic         pend_valid_q;

  logic         ir_load_c;
  logic         pc_load_c;
  logic [n-1:0] pc_load_val_c;
  logic         pend_set_c;
  logic         pend_clr_c;

  assign pc_plus4   = pc + n'(4);
  assign write_ok_c = pc_write && !misaligned_c;

  pc_next_mux #(.n(n)) u_next_mux (
    .pc_source    (pc_source),
    .pc_plus4     (pc_plus4),
    .jal          (jal),
    .branch       (branch),
    .jalr         (jalr),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .target_c     (target_c),
    .misaligned_c (misaligned_c)
  );

  // Request and address come straight from state and the PC register so they stay stable in FETCH.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc;
  assign busy           = (state_q == FETCH);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; PC writes during FETCH are deferred via the pending slot.
  always_comb begin
    state_d       = state_q;
    ir_load_c     = 1'b0;
    pc_load_c     = 1'b0;
    pc_load_val_c = pc;
    pend_set_c    = 1'b0;
    pend_clr_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = FETCH;
        end
        if (write_ok_c) begin
          pc_load_c     = 1'b1;
          pc_load_val_c = target_c;
        end
      end
      FETCH: begin
        if (imem.imem_ready) begin
          state_d    = IDLE;
          ir_load_c  = 1'b1;
          pend_clr_c = 1'b1;
          if (write_ok_c) begin
            pc_load_c     = 1'b1;
            pc_load_val_c = target_c;
          end else if (pend_valid_q) begin
            pc_load_c     = 1'b1;
            pc_load_val_c = pend_q;
          end
        end else if (write_ok_c) begin
          pend_set_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // PC, IR, pending target and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VEC;
      ir            <= '0;
      ir_valid      <= 1'b0;
      misalign_trap <= 1'b0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
    end else begin
      ir_valid      <= ir_load_c;
      misalign_trap <= pc_write && misaligned_c;
      if (pc_load_c) begin
        pc <= pc_load_val_c;
      end
      if (ir_load_c) begin
        ir <= imem.imem_rdata;
      end
      if (pend_clr_c) begin
        pend_valid_q <= 1'b0;
      end else if (pend_set_c) begin
        pend_q       <= target_c;
        pend_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with hand-computed expected values.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        pc_write;
  logic [2:0]  pc_source;
  logic [31:0] jal, branch, jalr, mtvec, mepc;
  logic [31:0] pc, pc_plus4, ir;
  logic        ir_valid, busy, misalign_trap;

  int n_vec  = 0;
  int n_miss = 0;

  pc_fetch_ctrl_if #(.n(32)) imem ();

  pc_fetch_ctrl #(.n(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .pc_write      (pc_write),
    .pc_source     (pc_source),
    .jal           (jal),
    .branch        (branch),
    .jalr          (jalr),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .imem          (imem),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; pc_write = 1'b0; pc_source = 3'd0;
    jal = '0; branch = '0; jalr = '0; mtvec = '0; mepc = '0;
    imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    step(); step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_ir", ir, 32'h0);
    check_eq("rst_ir_valid", 32'(ir_valid), 32'h0);
    check_eq("rst_req", 32'(imem.imem_req), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_trap", 32'(misalign_trap), 32'h0);
    rst_n = 1'b1;
    step();

    // First fetch with ready on the first FETCH cycle.
    fetch_en = 1'b1; imem.imem_ready = 1'b1; imem.imem_rdata = 32'h0000_0013;
    step();
    fetch_en = 1'b0;
    check_eq("f1_req", 32'(imem.imem_req), 32'h1);
    check_eq("f1_addr", imem.imem_addr, 32'h0);
    check_eq("f1_busy", 32'(busy), 32'h1);
    check_eq("f1_irv_early", 32'(ir_valid), 32'h0);
    step();
    imem.imem_ready = 1'b0;
    check_eq("f1_ir", ir, 32'h0000_0013);
    check_eq("f1_irv", 32'(ir_valid), 32'h1);
    check_eq("f1_busy_done", 32'(busy), 32'h0);
    step();
    check_eq("f1_irv_once", 32'(ir_valid), 32'h0);
    check_eq("f1_ir_hold", ir, 32'h0000_0013);

    // JAL writes in IDLE, aligned then misaligned.
    pc_source = 3'd3; jal = 32'h100; pc_write = 1'b1;
    step();
    check_eq("jal_pc100", pc, 32'h100);
    jal = 32'h200;
    step();
    check_eq("jal_pc200", pc, 32'h200);
    check_eq("jal_plus4", pc_plus4, 32'h204);
    check_eq("jal_no_trap", 32'(misalign_trap), 32'h0);
    jal = 32'h202;
    step();
    pc_write = 1'b0;
    check_eq("jal_mis_pc", pc, 32'h200);
    check_eq("jal_mis_trap", 32'(misalign_trap), 32'h1);
    step();
    check_eq("jal_trap_once", 32'(misalign_trap), 32'h0);

    // Branch write during a stalled fetch is deferred until completion.
    pc_source = 3'd2; branch = 32'h40; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("br_pc40", pc, 32'h40);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check_eq("st_addr_c1", imem.imem_addr, 32'h40);
    step();
    check_eq("st_addr_c2", imem.imem_addr, 32'h40);
    branch = 32'h80; pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    check_eq("st_addr_c3", imem.imem_addr, 32'h40);
    check_eq("st_pc_held", pc, 32'h40);
    check_eq("st_busy", 32'(busy), 32'h1);
    step();
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'hABCD_0093;
    check_eq("st_addr_c4", imem.imem_addr, 32'h40);
    step();
    imem.imem_ready = 1'b0;
    check_eq("st_pc_after", pc, 32'h80);
    check_eq("st_ir", ir, 32'hABCD_0093);
    check_eq("st_irv", 32'(ir_valid), 32'h1);

    // Two writes in one FETCH (last wins); a misaligned third write leaves pending alone.
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    pc_source = 3'd1; jalr = 32'h10; pc_write = 1'b1;
    step();
    pc_source = 3'd5; mepc = 32'h20;
    step();
    pc_source = 3'd3; jal = 32'h33;
    step();
    pc_write = 1'b0;
    check_eq("two_trap", 32'(misalign_trap), 32'h1);
    check_eq("two_pc_held", pc, 32'h80);
    imem.imem_ready = 1'b1;
    step();
    imem.imem_ready = 1'b0;
    check_eq("two_pc_final", pc, 32'h20);

    // Write on the completing edge lands at that edge.
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    pc_source = 3'd4; mtvec = 32'h300; pc_write = 1'b1; imem.imem_ready = 1'b1;
    step();
    pc_write = 1'b0; imem.imem_ready = 1'b0;
    check_eq("cmp_edge_pc", pc, 32'h300);

    // Reset pulsed mid-fetch.
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check_eq("rf_req_before", 32'(imem.imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rf_req_drop", 32'(imem.imem_req), 32'h0);
    check_eq("rf_pc", pc, 32'h0);
    check_eq("rf_ir", ir, 32'h0);
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    step();
    check_eq("rf_ir_after", ir, 32'h0);
    check_eq("rf_irv_after", 32'(ir_valid), 32'h0);
    check_eq("rf_busy_after", 32'(busy), 32'h0);
    check_eq("rf_pc_after", pc, 32'h0);
    imem.imem_ready = 1'b0;
    step();
    check_eq("rf_irv_later", 32'(ir_valid), 32'h0);

    // pc+4 wrap and reserved source code.
    pc_source = 3'd4; mtvec = 32'hFFFF_FFFC; pc_write = 1'b1;
    step();
    check_eq("wrap_pre", pc, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'h0);
    pc_source = 3'd0;
    step();
    check_eq("wrap_pc0", pc, 32'h0);
    pc_source = 3'd6; jal = 32'h3;
    step();
    check_eq("rsv6_pc", pc, 32'h4);
    pc_source = 3'd7;
    step();
    pc_write = 1'b0;
    check_eq("rsv7_pc", pc, 32'h8);
    check_eq("rsv_no_trap", 32'(misalign_trap), 32'h0);
    check_eq("rsv_plus4", pc_plus4, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and instruction-fetch controller for the multicycle RV32I core.
- Sits directly downstream of the branch address generator: consumes its jal, branch and jalr targets, plus mtvec/mepc from the CSR file.
- Holds the architectural PC, selects and commits the next PC on the control FSM's command, and runs a request/ready fetch handshake to instruction memory, latching the returned word into the IR.

Parameters:
- n, 32, datapath/address width.
- RESET_VEC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  control FSM requests an instruction fetch at the current PC.
- pc_write  in  1  commit the selected next PC.
- pc_source  in  3  0=pc+4, 1=jalr, 2=branch, 3=jal, 4=mtvec, 5=mepc, 6/7 reserved (treated as 0).
- jal  in  n  JAL target.
- branch  in  n  branch target.
- jalr  in  n  JALR target.
- mtvec  in  n  trap vector.
- mepc  in  n  trap return address.
- imem_ready  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  n  fetched instruction word.
- imem_req  out  1  fetch request.
- imem_addr  out  n  fetch address; equals pc.
- pc  out  n  current PC.
- pc_plus4  out  n  pc + 4, combinational.
- ir  out  n  latched instruction.
- ir_valid  out  1  one-cycle pulse: ir updated.
- busy  out  1  high while in FETCH.
- misalign_trap  out  1  one-cycle pulse: rejected misaligned target.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VEC, ir=0, state=IDLE.
  - ir_valid, imem_req, busy and misalign_trap all 0.
  - Pending write cleared.
  - Takes effect immediately, including mid-fetch. An imem_ready arriving after reset deasserts is ignored unless a new FETCH has started.
- FSM states: IDLE, FETCH.
  - IDLE -> FETCH on fetch_en.
  - FETCH -> IDLE on the edge where imem_ready=1. At that edge ir<=imem_rdata, and ir_valid is high for the following cycle only.
  - In FETCH: imem_req=1, busy=1, imem_addr=pc held stable. No timeout: the block waits indefinitely.
  - Minimum latency fetch_en -> ir_valid: 2 cycles (fetch_en edge, then ready in the first FETCH cycle).
  - fetch_en while in FETCH is ignored.
- Next-PC selection:
  - Combinational mux on pc_source.
  - All additions are modulo 2^n; pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- Misalignment check:
  - Applies to sources 1-3 only; mtvec/mepc/pc+4 are trusted.
  - A target with bits[1:0]!=0 is rejected: pc is unchanged and misalign_trap pulses one cycle after the pc_write edge.
  - jalr is used as supplied; bit-0 clearing is the generator's responsibility.
- pc_write in IDLE: pc<=selected target at that edge.
- pc_write together with fetch_en in IDLE:
  - Both are accepted.
  - The FETCH that follows uses the new PC, because imem_addr is driven from the pc register.
- pc_write during FETCH:
  - The target is sampled and checked that cycle.
  - A legal target goes to a one-deep pending register; pc must not change while imem_addr is in use.
  - The pending value is applied to pc at the FETCH->IDLE edge.
  - A second pc_write during the same FETCH overwrites the pending value (last wins).
  - A misaligned target pulses misalign_trap and leaves the pending register untouched.
- pc_write on the same edge the fetch completes: treated as a FETCH-state write, so pc gets the target at that edge.
- ir holds its value until the next completed fetch. ir_valid is never high on two consecutive cycles.

Decomposition:
- Shared core package gets:
  - pc_src_t enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC).
  - fetch_state_t (IDLE, FETCH).
  - constant RESET_VEC_DEFAULT.
- One natural sub-module: pc_next_mux. It is combinational: source select plus misalignment flag. It is reusable by a later pipelined core.

Test Plan:
- Reset release, fetch_en=1, imem_ready=1 on first FETCH cycle, rdata=32'h0000_0013 -> imem_addr=0, ir=32'h13, ir_valid pulses exactly once, 2 cycles after fetch_en.
- IDLE, pc=32'h100, pc_source=3, jal=32'h200, pc_write=1 -> pc=32'h200, pc_plus4=32'h204. Repeat with jal=32'h202 -> pc stays 32'h200 and misalign_trap pulses.
- fetch_en at pc=32'h40, imem_ready low 3 cycles; pc_write with pc_source=2, branch=32'h80 in the 2nd cycle -> imem_addr stays 32'h40 throughout; pc=32'h80 after completion.
- Two pc_writes in one FETCH (jalr=32'h10, then mepc=32'h20) -> final pc=32'h20.
- rst_n pulsed low mid-FETCH, then imem_ready=1 -> imem_req drops immediately, ir stays 0, no ir_valid, pc=RESET_VEC.
- pc=32'hFFFF_FFFC, pc_source=0, pc_write -> pc=0. pc_source=6 -> behaves as pc+4.
